// File: rtl/quad_capture_writer_if.sv
// Avalon-MM write-master bundle between quad_capture_writer and the sample memory slave.
interface quad_capture_writer_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              waitrequest;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;

  modport master (
    input  waitrequest,
    output address, byteenable, chipselect, write, writedata, clken
  );

  modport slave (
    output waitrequest,
    input  address, byteenable, chipselect, write, writedata, clken
  );
endinterface

// File: rtl/quad_capture_writer.sv
// Quadrature position decoder with periodic sampling into a 32-bit record memory over Avalon-MM.
// Optional index (Z) channel enabled by defining QUAD_CAPTURE_INDEX_EN.
module quad_capture_writer #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned DEPTH      = 5120,
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned WRAP       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 quad_a,
  input  logic                 quad_b,
`ifdef QUAD_CAPTURE_INDEX_EN
  input  logic                 quad_z,
`endif
  input  logic                 start,
  input  logic                 stop,
  quad_capture_writer_if.master mem,
  output logic [15:0]          position,
  output logic [ADDR_W:0]      wr_ptr,
  output logic                 busy,
  output logic                 full,
  output logic                 overrun
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(BASE_ADDR + DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam int unsigned       TW      = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0]     TMAX    = TW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WRITE,
    S_FULL
  } state_t;

  state_t            r_state, w_state_next;

  logic              r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  logic [1:0]        r_ab_prev;
  logic [15:0]       r_position;
  logic              r_err_sticky;
  logic [TW-1:0]     r_timer;
  logic [7:0]        r_seq;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_full, r_overrun, r_stop_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_cs;
  logic [31:0]       r_data;

  logic [1:0]        w_ab;
  logic              w_step_up, w_step_dn, w_illegal;
  logic              w_index_rise, w_index_bit;
  logic              w_busy, w_tick, w_stop_seen;

  logic [7:0]        w_seq_next;
  logic [ADDR_W:0]   w_wr_ptr_next;
  logic              w_full_next, w_overrun_next, w_stop_pend_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_cs_next;
  logic [31:0]       w_data_next;

  // ---------------------------------------------------------------- input path
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_s1    <= 1'b0;
      r_a_s2    <= 1'b0;
      r_b_s1    <= 1'b0;
      r_b_s2    <= 1'b0;
      r_ab_prev <= 2'b00;
    end else begin
      r_a_s1    <= quad_a;
      r_a_s2    <= r_a_s1;
      r_b_s1    <= quad_b;
      r_b_s2    <= r_b_s1;
      r_ab_prev <= w_ab;
    end
  end

  assign w_ab = {r_a_s2, r_b_s2};

  always_comb begin
    w_step_up = 1'b0;
    w_step_dn = 1'b0;
    w_illegal = 1'b0;
    case ({r_ab_prev, w_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step_up = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_step_dn = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef QUAD_CAPTURE_INDEX_EN
  logic r_z_s1, r_z_s2, r_z_prev, r_index_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_z_s1       <= 1'b0;
      r_z_s2       <= 1'b0;
      r_z_prev     <= 1'b0;
      r_index_seen <= 1'b0;
    end else begin
      r_z_s1   <= quad_z;
      r_z_s2   <= r_z_s1;
      r_z_prev <= r_z_s2;
      if (w_index_rise)
        r_index_seen <= 1'b1;
      else if (start)
        r_index_seen <= 1'b0;
    end
  end

  assign w_index_rise = r_z_s2 & ~r_z_prev;
  assign w_index_bit  = r_index_seen;
`else
  assign w_index_rise = 1'b0;
  assign w_index_bit  = 1'b0;
`endif

  // Decoder runs regardless of logging state; start never touches position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_position   <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_index_rise)
        r_position <= '0;
      else if (w_step_up)
        r_position <= r_position + 16'd1;
      else if (w_step_dn)
        r_position <= r_position - 16'd1;

      if (w_illegal)
        r_err_sticky <= 1'b1;
      else if (start)
        r_err_sticky <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- sample timer
  assign w_busy = (r_state == S_ARM) || (r_state == S_WRITE);
  assign w_tick = w_busy && (r_timer == TMAX);

  always_ff @(posedge clk) begin
    if (reset || start || !w_busy || w_tick)
      r_timer <= '0;
    else
      r_timer <= r_timer + 1'b1;
  end

  // ---------------------------------------------------------------- logging FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_seq       <= '0;
      r_wr_ptr    <= '0;
      r_full      <= 1'b0;
      r_overrun   <= 1'b0;
      r_stop_pend <= 1'b0;
      r_addr      <= '0;
      r_cs        <= 1'b0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_seq       <= w_seq_next;
      r_wr_ptr    <= w_wr_ptr_next;
      r_full      <= w_full_next;
      r_overrun   <= w_overrun_next;
      r_stop_pend <= w_stop_pend_next;
      r_addr      <= w_addr_next;
      r_cs        <= w_cs_next;
      r_data      <= w_data_next;
    end
  end

  assign w_stop_seen = stop | r_stop_pend;

  always_comb begin
    w_state_next     = r_state;
    w_seq_next       = r_seq;
    w_wr_ptr_next    = r_wr_ptr;
    w_full_next      = r_full;
    w_overrun_next   = r_overrun;
    w_stop_pend_next = r_stop_pend;
    w_addr_next      = r_addr;
    w_cs_next        = r_cs;
    w_data_next      = r_data;

    // start outranks stop and any in-flight write in every state.
    if (start) begin
      w_state_next     = S_ARM;
      w_seq_next       = '0;
      w_wr_ptr_next    = '0;
      w_full_next      = 1'b0;
      w_overrun_next   = 1'b0;
      w_stop_pend_next = 1'b0;
      w_addr_next      = BASE;
      w_cs_next        = 1'b0;
    end else begin
      case (r_state)
        S_ARM: begin
          if (stop) begin
            w_state_next = S_IDLE;
          end else if (w_tick) begin
            w_state_next = S_WRITE;
            w_cs_next    = 1'b1;
            w_data_next  = {r_seq, r_err_sticky, w_index_bit, 6'b000000, r_position};
          end
        end
        S_WRITE: begin
          if (w_tick)
            w_overrun_next = 1'b1;
          if (stop)
            w_stop_pend_next = 1'b1;
          if (!mem.waitrequest) begin
            w_cs_next        = 1'b0;
            w_stop_pend_next = 1'b0;
            w_seq_next       = r_seq + 8'd1;
            if (r_wr_ptr != DEPTH_W)
              w_wr_ptr_next = r_wr_ptr + 1'b1;
            if (r_addr == LAST) begin
              w_full_next = 1'b1;
              if (WRAP != 0) begin
                w_addr_next  = BASE;
                w_state_next = w_stop_seen ? S_IDLE : S_ARM;
              end else begin
                w_addr_next  = r_addr + 1'b1;
                w_state_next = w_stop_seen ? S_IDLE : S_FULL;
              end
            end else begin
              w_addr_next  = r_addr + 1'b1;
              w_state_next = w_stop_seen ? S_IDLE : S_ARM;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign mem.address    = r_addr;
  assign mem.byteenable = 4'hF;
  assign mem.chipselect = r_cs;
  assign mem.write      = r_cs;
  assign mem.writedata  = r_data;
  assign mem.clken      = 1'b1;

  assign position = r_position;
  assign wr_ptr   = r_wr_ptr;
  assign busy     = w_busy;
  assign full     = r_full;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_quad_capture_writer.sv
// Directed bench for quad_capture_writer: three instances (long linear, DEPTH=4 linear, DEPTH=4 circular).
module tb_quad_capture_writer;

  localparam int unsigned AW     = 8;
  localparam int unsigned BASE_A = 8;
  localparam int unsigned BASE_S = 2;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic quad_a   = 1'b0;
  logic quad_b   = 1'b0;
  logic start    = 1'b0;
  logic stop     = 1'b0;
  logic wait_req = 1'b0;
`ifdef QUAD_CAPTURE_INDEX_EN
  logic quad_z   = 1'b0;
`endif

  logic [15:0] pos_a, pos_b, pos_c;
  logic [AW:0] ptr_a, ptr_b, ptr_c;
  logic busy_a, busy_b, busy_c, full_a, full_b, full_c, ovr_a, ovr_b, ovr_c;

  int errors = 0;
  int checks = 0;

  quad_capture_writer_if #(.ADDR_W(AW)) if_a ();
  quad_capture_writer_if #(.ADDR_W(AW)) if_b ();
  quad_capture_writer_if #(.ADDR_W(AW)) if_c ();

  assign if_a.waitrequest = wait_req;
  assign if_b.waitrequest = wait_req;
  assign if_c.waitrequest = wait_req;

  quad_capture_writer #(.ADDR_W(AW), .BASE_ADDR(BASE_A), .DEPTH(64), .SAMPLE_DIV(4), .WRAP(0)) dut_a (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
`ifdef QUAD_CAPTURE_INDEX_EN
    .quad_z(quad_z),
`endif
    .start(start), .stop(stop), .mem(if_a),
    .position(pos_a), .wr_ptr(ptr_a), .busy(busy_a), .full(full_a), .overrun(ovr_a)
  );

  quad_capture_writer #(.ADDR_W(AW), .BASE_ADDR(BASE_S), .DEPTH(4), .SAMPLE_DIV(4), .WRAP(0)) dut_b (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
`ifdef QUAD_CAPTURE_INDEX_EN
    .quad_z(quad_z),
`endif
    .start(start), .stop(stop), .mem(if_b),
    .position(pos_b), .wr_ptr(ptr_b), .busy(busy_b), .full(full_b), .overrun(ovr_b)
  );

  quad_capture_writer #(.ADDR_W(AW), .BASE_ADDR(BASE_S), .DEPTH(4), .SAMPLE_DIV(4), .WRAP(1)) dut_c (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
`ifdef QUAD_CAPTURE_INDEX_EN
    .quad_z(quad_z),
`endif
    .start(start), .stop(stop), .mem(if_c),
    .position(pos_c), .wr_ptr(ptr_c), .busy(busy_c), .full(full_c), .overrun(ovr_c)
  );

  always #5 clk = ~clk;

  // Completed writes, captured mid-cycle where strobes and waitrequest are stable.
  logic [AW-1:0] qa_addr[$], qb_addr[$], qc_addr[$];
  logic [31:0]   qa_data[$], qb_data[$], qc_data[$];

  always @(negedge clk) begin
    if (if_a.chipselect && !wait_req) begin qa_addr.push_back(if_a.address); qa_data.push_back(if_a.writedata); end
    if (if_b.chipselect && !wait_req) begin qb_addr.push_back(if_b.address); qb_data.push_back(if_b.writedata); end
    if (if_c.chipselect && !wait_req) begin qc_addr.push_back(if_c.address); qc_data.push_back(if_c.writedata); end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qa_addr.delete(); qa_data.delete();
    qb_addr.delete(); qb_data.delete();
    qc_addr.delete(); qc_data.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic fwd_step();
    case ({quad_a, quad_b})
      2'b00:   quad_b = 1'b1;
      2'b01:   quad_a = 1'b1;
      2'b11:   quad_b = 1'b0;
      default: quad_a = 1'b0;
    endcase
  endtask

  task automatic rev_step();
    case ({quad_a, quad_b})
      2'b00:   quad_a = 1'b1;
      2'b10:   quad_b = 1'b1;
      2'b11:   quad_a = 1'b0;
      default: quad_b = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(3); reset = 1'b0; tick(20);
    checks++; if (if_a.chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", if_a.chipselect); end
    checks++; if (if_a.write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", if_a.write); end
    checks++; if (if_a.byteenable !== 4'hF) begin errors++; $display("FAIL reset_be: got %h want f", if_a.byteenable); end
    checks++; if (if_a.clken !== 1'b1) begin errors++; $display("FAIL reset_clken: got %b want 1", if_a.clken); end
    checks++; if (if_a.address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", if_a.address); end
    checks++; if (if_a.writedata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", if_a.writedata); end
    checks++; if (pos_a !== 16'h0000) begin errors++; $display("FAIL reset_pos: got %h want 0000", pos_a); end
    checks++; if ({busy_a, full_a, ovr_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy_a, full_a, ovr_a}); end
    checks++; if (ptr_a !== 9'd0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", ptr_a); end
    checks++; if (qa_addr.size() !== 0) begin errors++; $display("FAIL reset_nowrite: got %0d writes want 0", qa_addr.size()); end
  endtask

  task automatic test_forward();
    int n, n2;
    clear_q();
    pulse_start();
    for (int s = 0; s < 8; s++) begin fwd_step(); tick(5); end
    tick(12);
    checks++; if (pos_a !== 16'd8) begin errors++; $display("FAIL fwd_pos: got %0d want 8", pos_a); end
    n = qa_data.size();
    checks++; if (n < 10) begin errors++; $display("FAIL fwd_count: got %0d records want >=10", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (qa_addr[i] !== 8'(BASE_A + i)) begin errors++; $display("FAIL fwd_addr[%0d]: got %h want %h", i, qa_addr[i], 8'(BASE_A + i)); end
      checks++; if (qa_data[i][31:16] !== {8'(i), 8'h00}) begin errors++; $display("FAIL fwd_hdr[%0d]: got %h want %h", i, qa_data[i][31:16], {8'(i), 8'h00}); end
      if (i > 0) begin
        checks++; if ($signed(qa_data[i][15:0]) < $signed(qa_data[i-1][15:0])) begin errors++; $display("FAIL fwd_mono[%0d]: got %0d after %0d", i, qa_data[i][15:0], qa_data[i-1][15:0]); end
      end
    end
    if (n > 0) begin
      checks++; if (qa_data[n-1][15:0] !== 16'd8) begin errors++; $display("FAIL fwd_last: got %0d want 8", qa_data[n-1][15:0]); end
    end
    checks++; if (ptr_a !== 9'(n)) begin errors++; $display("FAIL fwd_ptr: got %0d want %0d", ptr_a, n); end
    pulse_stop();
    tick(1);
    n2 = qa_data.size();
    tick(12);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy_a); end
    checks++; if (qa_data.size() !== n2) begin errors++; $display("FAIL stop_nowrite: got %0d writes want %0d", qa_data.size(), n2); end
  endtask

  task automatic test_depth();
    clear_q();
    pulse_start();
    checks++; if (pos_a !== 16'd8) begin errors++; $display("FAIL start_keeps_pos: got %0d want 8", pos_a); end
    tick(30);
    checks++; if (qb_addr.size() !== 4) begin errors++; $display("FAIL lin_count: got %0d want 4", qb_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (qb_addr[i] !== 8'(BASE_S + i)) begin errors++; $display("FAIL lin_addr[%0d]: got %h want %h", i, qb_addr[i], 8'(BASE_S + i)); end
      checks++; if (qb_data[i][31:24] !== 8'(i)) begin errors++; $display("FAIL lin_seq[%0d]: got %0d want %0d", i, qb_data[i][31:24], i); end
    end
    checks++; if ({full_b, busy_b, if_b.chipselect} !== 3'b100) begin errors++; $display("FAIL lin_flags: got %b want 100", {full_b, busy_b, if_b.chipselect}); end
    checks++; if (ptr_b !== 9'd4) begin errors++; $display("FAIL lin_ptr: got %0d want 4", ptr_b); end
    checks++; if (qc_addr.size() < 5) begin errors++; $display("FAIL wrap_count: got %0d want >=5", qc_addr.size()); end
    if (qc_addr.size() >= 5) begin
      checks++; if (qc_addr[4] !== 8'(BASE_S)) begin errors++; $display("FAIL wrap_addr: got %h want %h", qc_addr[4], 8'(BASE_S)); end
      checks++; if (qc_data[4][31:24] !== 8'd4) begin errors++; $display("FAIL wrap_seq: got %0d want 4", qc_data[4][31:24]); end
    end
    checks++; if ({full_c, busy_c} !== 2'b11) begin errors++; $display("FAIL wrap_flags: got %b want 11", {full_c, busy_c}); end
    checks++; if (ptr_c !== 9'd4) begin errors++; $display("FAIL wrap_ptr: got %0d want 4", ptr_c); end
    pulse_stop();
    tick(4);
  endtask

  task automatic test_reverse();
    int n;
    reset = 1'b1; tick(2); reset = 1'b0; tick(2);
    checks++; if (pos_a !== 16'h0000) begin errors++; $display("FAIL rev_zero: got %h want 0000", pos_a); end
    clear_q();
    pulse_start();
    for (int s = 0; s < 3; s++) begin rev_step(); tick(5); end
    tick(12);
    checks++; if (pos_a !== 16'hFFFD) begin errors++; $display("FAIL rev_pos: got %h want fffd", pos_a); end
    n = qa_data.size();
    if (n > 0) begin
      checks++; if (qa_data[n-1][23:0] !== 24'h00FFFD) begin errors++; $display("FAIL rev_rec: got %h want 00fffd", qa_data[n-1][23:0]); end
    end
    quad_a = ~quad_a; quad_b = ~quad_b;
    tick(14);
    checks++; if (pos_a !== 16'hFFFD) begin errors++; $display("FAIL illegal_pos: got %h want fffd", pos_a); end
    n = qa_data.size();
    checks++; if (n < 6) begin errors++; $display("FAIL rev_count: got %0d want >=6", n); end
    if (n > 0) begin
      checks++; if (qa_data[n-1][23:0] !== 24'h80FFFD) begin errors++; $display("FAIL illegal_rec: got %h want 80fffd", qa_data[n-1][23:0]); end
      checks++; if (qa_data[n-1][31:24] !== 8'(n - 1)) begin errors++; $display("FAIL rev_seq: got %0d want %0d", qa_data[n-1][31:24], n - 1); end
    end
    pulse_stop();
    tick(4);
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL start_wins: got busy %b want 1", busy_a); end
    pulse_stop();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stop_arm: got busy %b want 0", busy_a); end
  endtask

  task automatic test_waitrequest();
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_data;
    clear_q();
    pulse_start();
    for (int i = 0; i < 20 && !if_a.chipselect; i++) tick(1);
    checks++; if (if_a.chipselect !== 1'b1) begin errors++; $display("FAIL wr_timeout: got cs %b want 1", if_a.chipselect); end
    wait_req = 1'b1;
    cap_addr = if_a.address;
    cap_data = if_a.writedata;
    checks++; if ({cap_addr, cap_data[31:24]} !== {8'(BASE_A), 8'd0}) begin errors++; $display("FAIL wr_first: got %h want %h", {cap_addr, cap_data[31:24]}, {8'(BASE_A), 8'd0}); end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++; if ({if_a.chipselect, if_a.address, if_a.writedata} !== {1'b1, cap_addr, cap_data}) begin
        errors++; $display("FAIL wr_hold[%0d]: got %h want %h", i, {if_a.chipselect, if_a.address, if_a.writedata}, {1'b1, cap_addr, cap_data});
      end
    end
    wait_req = 1'b0;
    tick(12);
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL overrun: got %b want 1", ovr_a); end
    checks++; if (qa_data.size() < 2) begin errors++; $display("FAIL wr_count: got %0d want >=2", qa_data.size()); end
    if (qa_data.size() >= 2) begin
      checks++; if (qa_data[0] !== cap_data) begin errors++; $display("FAIL wr_data0: got %h want %h", qa_data[0], cap_data); end
      checks++; if ({qa_addr[1], qa_data[1][31:24]} !== {8'(BASE_A + 1), 8'd1}) begin errors++; $display("FAIL wr_next: got %h want %h", {qa_addr[1], qa_data[1][31:24]}, {8'(BASE_A + 1), 8'd1}); end
    end
    pulse_stop();
    tick(4);
  endtask

`ifdef QUAD_CAPTURE_INDEX_EN
  task automatic test_index();
    int n;
    quad_a = 1'b0; quad_b = 1'b0; tick(4);
    reset = 1'b1; tick(2); reset = 1'b0; tick(2);
    for (int s = 0; s < 57; s++) begin fwd_step(); tick(2); end
    tick(5);
    checks++; if (pos_a !== 16'd57) begin errors++; $display("FAIL idx_pre: got %0d want 57", pos_a); end
    clear_q();
    pulse_start();
    tick(6);
    quad_z = 1'b1;
    tick(2);
    checks++; if (pos_a !== 16'd57) begin errors++; $display("FAIL idx_early: got %0d want 57", pos_a); end
    tick(1);
    checks++; if (pos_a !== 16'd0) begin errors++; $display("FAIL idx_zero: got %0d want 0", pos_a); end
    quad_z = 1'b0;
    tick(12);
    n = qa_data.size();
    checks++; if (n < 3) begin errors++; $display("FAIL idx_count: got %0d want >=3", n); end
    if (n > 0) begin
      checks++; if (qa_data[n-1][23:0] !== 24'h400000) begin errors++; $display("FAIL idx_rec: got %h want 400000", qa_data[n-1][23:0]); end
    end
    pulse_stop();
    tick(4);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_depth();
    test_reverse();
    test_start_stop();
    test_waitrequest();
`ifdef QUAD_CAPTURE_INDEX_EN
    test_index();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_capture_writer.md
Name: quad_capture_writer

Overview:
- Upstream stage of the on-chip sample memory. Decodes a quadrature encoder (A/B) into a signed position count and samples it every SAMPLE_DIV clocks.
- Writes one 32-bit record per sample into the 5120×32 single-port memory through its Avalon-MM slave (address/byteenable/chipselect/write/writedata).
- Supports linear (stop-when-full) or circular logging. The Nios software reads the records back through the other memory slave.

Parameters:
- ADDR_W, 13, word-address width; matches the memory address input.
- BASE_ADDR, 0, first word address written.
- DEPTH, 5120, number of words used; BASE_ADDR+DEPTH must be ≤ 2^ADDR_W.
- SAMPLE_DIV, 1000, clocks between samples; must be ≥ 2.
- WRAP, 0, 0 = stop at full; 1 = circular, overwrite oldest.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- quad_a  in  1  encoder channel A, asynchronous.
- quad_b  in  1  encoder channel B, asynchronous.
- start  in  1  one-cycle pulse: clear pointer/seq/flags, begin logging.
- stop  in  1  one-cycle pulse: end logging after any pending write.
- mem_waitrequest  in  1  interconnect stall; tie 0 for direct connection.
- mem_address  out  ADDR_W  word address.
- mem_byteenable  out  4  always 4'hF.
- mem_chipselect  out  1  write request, qualifies address/data.
- mem_write  out  1  equals mem_chipselect.
- mem_writedata  out  32  record word.
- mem_clken  out  1  constant 1.
- position  out  16  live signed position count.
- wr_ptr  out  ADDR_W+1  records written since start, saturating at DEPTH.
- busy  out  1  logging active.
- full  out  1  DEPTH records written (sticky; set in both WRAP modes).
- overrun  out  1  sticky: a sample was dropped.

Behaviour:
- Reset values: all outputs 0 except mem_byteenable=4'hF and mem_clken=1. The FSM enters IDLE and the sync flops clear. A reset mid-write abandons the write: chipselect drops the next cycle and no retry follows.
- Input path: 2-flop synchronizer on A and B, then a prev-state register.
- Decoder: 4× decode. The valid Gray step 00→01→11→10→00 increments position; the reverse sequence decrements.
- Illegal step: both bits changing in one clock sets err_sticky and leaves position unchanged.
- Latency: position changes 3 clocks after a pin edge.
- Position width: 16-bit two's complement. It wraps 32767→-32768 and -32768→32767 with no flag.
- The decoder runs continuously, independent of logging. start does not clear position.
- Timer: counts 0..SAMPLE_DIV-1 while busy and holds at 0 when not busy. tick = busy & (timer == SAMPLE_DIV-1).
- Record word: [31:24] seq (8-bit, wraps 255→0), [23] err_sticky, [22] index_seen, [21:16] 0, [15:0] position as it stands at tick.
- FSM states:
  - IDLE: start → ARM. Clears seq, wr_ptr, full, overrun and err_sticky; address = BASE_ADDR.
  - ARM: tick → WRITE. Latches the record; chipselect = write = 1 from the next cycle.
  - WRITE: holds address/data/chipselect while mem_waitrequest=1. On the first cycle with mem_waitrequest=0 the write completes: seq+1, wr_ptr+1 (saturating), address+1.
    - Then: → IDLE if stop was seen. Otherwise → ARM if not at end of buffer.
    - End of buffer: WRAP=1 → address = BASE_ADDR, set full, → ARM. WRAP=0 → set full, → FULL.
  - FULL: busy=0; only start leaves (→ ARM with clears).
- Write timing: with mem_waitrequest=0 every write completes in exactly 1 cycle, one write per tick.
- Overrun: a tick while in WRITE drops that sample and sets overrun. seq is not incremented for the dropped sample.
- stop: in ARM → IDLE next cycle. In WRITE it is latched and the FSM goes to IDLE after the write completes. In IDLE/FULL it is ignored.
- start and stop in the same cycle: start wins.
- start while busy: restarts (clears) and aborts any pending write. busy = state ∈ {ARM, WRITE}.

Optional Feature:
- Macro: QUAD_CAPTURE_INDEX_EN.
- Defined:
  - Adds input quad_z (1 bit, async, 2-flop synchronized).
  - A synchronized rising edge of Z forces position to 0, overriding any same-cycle count step, and sets index_seen (sticky, cleared by start). Record bit 22 reports index_seen.
- Undefined: no quad_z port; bit 22 is constant 0.

Test Plan:
- Reset, then idle 20 clocks → all mem_* strobes 0, position=0, busy=0, byteenable=4'hF.
- SAMPLE_DIV=4; drive 8 forward A/B quarter-steps spaced 5 clocks; start → first record written at BASE_ADDR; position reaches 8 and records increase monotonically; seq 0,1,2…
- Drive 3 reverse steps from position 0 → position = -3 = 16'hFFFD in the record; toggle A and B in the same clock → bit 23 set, position unchanged.
- DEPTH=4, WRAP=0 → exactly 4 writes at BASE..BASE+3, then full=1, busy=0, no further chipselect. WRAP=1 → the 5th write goes to BASE with seq=4 and full=1.
- mem_waitrequest held high for 6 clocks with SAMPLE_DIV=4 → address/data stable throughout, overrun=1, the next record's seq skips no value.
- Feature on: Z pulse at position 57 → position 0 three clocks later; the next record has bit 22=1.
